// File: rtl/stump_alu_pkg.sv
// Shared encodings for the registered Stump ALU: function codes, flag bit
// positions and the control state type.
package stump_alu_pkg;

    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_ADC  = 3'd1;
    localparam logic [2:0] FN_SUB  = 3'd2;
    localparam logic [2:0] FN_SBC  = 3'd3;
    localparam logic [2:0] FN_AND  = 3'd4;
    localparam logic [2:0] FN_OR   = 3'd5;
    localparam logic [2:0] FN_ADDR = 3'd6;
    localparam logic [2:0] FN_MUL  = 3'd7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    function automatic logic [3:0] mk_flags(input logic n, input logic z,
                                            input logic v, input logic c);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/stump_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// done is asserted during the final iteration; product is the value loaded on that edge.
module stump_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     hi_sum;

    // Low half of acc starts as the multiplier and shifts out as the product shifts in.
    always_comb begin
        hi_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        product = {hi_sum, acc[WIDTH-1:1]};
        done    = (cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc   <= product;
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/stump_seq_alu.sv
// Registered Stump ALU with valid/ready handshake, persistent NZVC register
// and an optional iterative multiply on func 7.
module stump_seq_alu #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       func,
    input  logic             c_in,
    input  logic             csh,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic [3:0]       flags_reg,
    output logic             busy
);
    import stump_alu_pkg::*;

    state_t             state, state_next;
    logic               accept, is_mul, mul_start, mul_done, mul_sf;
    logic [WIDTH-1:0]   b_op, alu_res, mul_res;
    logic               cin_op, carry_msb, v_bit, c_bit, alu_sf;
    logic [WIDTH:0]     sum;
    logic [3:0]         alu_flags, mul_flags;
    logic [2*WIDTH-1:0] mul_prod;

    assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (func == FN_MUL);
    assign mul_start = accept && is_mul;
    assign busy      = (state == MUL_RUN);

    always_comb begin
        b_op   = operand_b;
        cin_op = 1'b0;
        case (func)
            FN_ADC: cin_op = c_in;
            FN_SUB: begin b_op = ~operand_b; cin_op = 1'b1;  end
            FN_SBC: begin b_op = ~operand_b; cin_op = ~c_in; end
            default: ;
        endcase
        sum       = {1'b0, operand_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_op};
        carry_msb = operand_a[WIDTH-1] ^ b_op[WIDTH-1] ^ sum[WIDTH-1];

        alu_res = '0;
        v_bit   = 1'b0;
        c_bit   = 1'b0;
        case (func)
            FN_ADD, FN_ADC, FN_ADDR: begin
                alu_res = sum[WIDTH-1:0];
                v_bit   = carry_msb ^ sum[WIDTH];
                c_bit   = sum[WIDTH];
            end
            FN_SUB, FN_SBC: begin
                alu_res = sum[WIDTH-1:0];
                v_bit   = carry_msb ^ sum[WIDTH];
                c_bit   = ~sum[WIDTH];
            end
            FN_AND: begin alu_res = operand_a & operand_b; c_bit = csh; end
            FN_OR:  begin alu_res = operand_a | operand_b; c_bit = csh; end
            default: ;
        endcase
        alu_flags = mk_flags(alu_res[WIDTH-1], alu_res == '0, v_bit, c_bit);
        // ADDR never reports flags; func 7 only reaches here when it is illegal.
        if (func == FN_ADDR || func == FN_MUL)
            alu_flags = '0;
        alu_sf = set_flags && (func != FN_ADDR) && (func != FN_MUL);

        mul_res   = mul_prod[WIDTH-1:0];
        mul_flags = mk_flags(mul_res[WIDTH-1], mul_res == '0,
                             |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = MUL_RUN;
            MUL_RUN: if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags_out <= '0;
            flags_reg <= '0;
            mul_sf    <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && !is_mul) begin
                result    <= alu_res;
                flags_out <= alu_flags;
                out_valid <= 1'b1;
                if (alu_sf) flags_reg <= alu_flags;
            end else if (mul_start) begin
                mul_sf <= set_flags;
            end else if (state == MUL_RUN && mul_done) begin
                result    <= mul_res;
                flags_out <= mul_flags;
                out_valid <= 1'b1;
                if (mul_sf) flags_reg <= mul_flags;
            end
        end
    end

    if (MUL_EN) begin : g_mul
        stump_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst     (rst),
            .start   (mul_start),
            .a       (operand_a),
            .b       (operand_b),
            .done    (mul_done),
            .product (mul_prod)
        );
    end else begin : g_nomul
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

endmodule
